wb_dbg_master: RTL and testbench
================================

# wb_dbg_master

Serial-command Wishbone master that lets a host read and write any address on the system bus over a byte stream. It occupies a spare master port of `wb_conbus_top` (master 2) and competes with the LM32 instruction and data masters through the interconnect's arbiter. Its byte side connects to a receiver/transmitter pair through strobe and valid/ready handshakes. It decodes read and write commands, runs one single-beat Wishbone cycle per command with a timeout, and returns data or a status byte.

## Interface
Parameters:
- `timeout_cycles`, default 1024: clocks to wait for `m_ack_i`/`m_err_i` before aborting a cycle; legal range 2..65535.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid & tx_ready`.
- `m_adr_o`  out  32  Wishbone address.
- `m_dat_o`  out  32  Wishbone write data.
- `m_dat_i`  in  32  Wishbone read data.
- `m_sel_o`  out  4  byte select; constant 4'hF.
- `m_we_o`  out  1  write enable.
- `m_cyc_o`  out  1  cycle.
- `m_stb_o`  out  1  strobe; always equal to `m_cyc_o`.
- `m_ack_i`  in  1  slave acknowledge.
- `m_err_i`  in  1  slave error.
- `busy`  out  1  high in every state except IDLE.

## Operation
Command protocol (all multi-byte fields are big-endian, MSB first):
- Write: 0x57 ('W'), A3 A2 A1 A0, D3 D2 D1 D0. The response is 0x2E ('.') on ack, or 0x21 ('!') on error or timeout.
- Read: 0x52 ('R'), A3 A2 A1 A0. The response is D3 D2 D1 D0 on ack, or a single 0x21 on error or timeout.
- Any other byte received in IDLE is discarded, and the block stays in IDLE.

State machine:
- IDLE:
  - Byte 0x57 loads `we=1` and goes to ADDR.
  - Byte 0x52 loads `we=0` and goes to ADDR.
- ADDR: shifts each received byte into the address register (`adr <= {adr[23:0], rx_data}`). After the 4th byte it goes to DATA if `we`, else to BUS.
- DATA: shifts bytes into the write-data register the same way. After the 4th byte it goes to BUS.
- BUS: `m_cyc_o`/`m_stb_o` are high, and the timeout counter runs.
  - `m_ack_i` wins when it is seen (this includes `m_ack_i` and `m_err_i` arriving together). On a read it captures `m_dat_i`. It loads the response and goes to RESP.
  - `m_err_i` alone, or the counter reaching `timeout_cycles-1`, loads 0x21 and goes to RESP.
- RESP: presents the response bytes in order on `tx_data` with `tx_valid` high. Each byte advances on `tx_valid & tx_ready`. After the last accepted byte it returns to IDLE.

Rules:
- A 2-bit byte counter is used in ADDR, DATA and RESP. It is cleared on every state entry and wraps 3→0 on exit.
- `rx_valid` is ignored in BUS and RESP; those bytes are dropped.
- `m_adr_o` and `m_dat_o` are driven from their registers continuously. `m_we_o` is the latched `we`, qualified by `m_cyc_o`.
- The timeout counter is 16 bits wide, clears on entry to BUS, and increments once per clock while in BUS.

## Timing
- Reset values:
  - State is IDLE.
  - `tx_data`=0, `tx_valid`=0, `m_adr_o`=0, `m_dat_o`=0, `m_we_o`=0, `m_cyc_o`=0, `m_stb_o`=0, `busy`=0.
  - Counters are 0.
- `m_sel_o` is constant 4'hF, including during reset.
- Reset mid-operation aborts immediately. It drops `m_cyc_o` and `tx_valid` with no response.
- `m_cyc_o` rises on the clock edge after the cycle in which the last command byte has `rx_valid` high.
- `m_cyc_o` falls on the edge after the terminating `m_ack_i`/`m_err_i`, or at timeout. `tx_valid` rises on that same edge.
- Any ack that arrives after a timeout has already dropped `m_cyc_o` is ignored.
- Timeout fires after exactly `timeout_cycles` clocks with `m_cyc_o` high and no ack/err.
- `tx_valid` stays high and `tx_data` stays stable until accepted. The next response byte appears on the edge after acceptance.
- After the final response byte is accepted, `busy` falls on the next edge. A byte on the following cycle is decoded as a new command.

## Test plan
- Write, 0-wait slave: send 57 00 00 10 00 DE AD BE EF → one Wishbone cycle with adr=0x00001000, dat=0xDEADBEEF, we=1, sel=F; `tx_data` then carries 0x2E.
- Read with 3-cycle ack latency: send 52 70 00 00 00 while the slave returns 0x12345678 → one cycle with adr=0x70000000, we=0; `tx_data` then carries 12, 34, 56, 78 in that order, with `tx_ready` throttled at random.
- Timeout, `timeout_cycles`=8 and no responder: send 52 50 00 00 00 → `m_cyc_o` high for exactly 8 clocks, then `tx_data` carries 0x21 and `busy` returns to 0.
- Error, and ack/err together: slave asserts `m_err_i` → response 0x21. Slave asserts `m_ack_i` and `m_err_i` together on a write → response 0x2E.
- Garbage and dropped bytes: send 00 FF 41 in IDLE → no bus activity and `busy`=0. Bytes sent during BUS and RESP are not shifted into the address or data registers.
- Reset during BUS and during RESP → `m_cyc_o`, `tx_valid` and `busy` go to 0 immediately. A following full write command then completes normally.

Source files
------------

// File: rtl/wb_dbg_master.sv
// Byte-stream debug master: decodes 'W'/'R' commands from a serial receiver,
// runs one single-beat Wishbone cycle with a timeout, and returns data or a status byte.
module wb_dbg_master #(
   parameter int unsigned timeout_cycles = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] m_adr_o,
   output logic [31:0] m_dat_o,
   input  logic [31:0] m_dat_i,
   output logic [3:0]  m_sel_o,
   output logic        m_we_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   input  logic        m_ack_i,
   input  logic        m_err_i,
   output logic        busy
);

   // state  | meaning
   // IDLE   | waiting for a 'W' or 'R' command byte, others discarded
   // ADDR   | shifting in four address bytes, MSB first
   // DATA   | shifting in four write-data bytes, MSB first (writes only)
   // BUS    | Wishbone cycle in flight, timeout counter running
   // RESP   | presenting response bytes on the transmit handshake
   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_BUS,
      S_RESP
   } state_t;

   localparam logic [7:0]  CMD_WRITE = 8'h57;
   localparam logic [7:0]  CMD_READ  = 8'h52;
   localparam logic [7:0]  RSP_OK    = 8'h2E;
   localparam logic [7:0]  RSP_FAIL  = 8'h21;
   localparam logic [15:0] TMO_LAST  = 16'(timeout_cycles - 1);

   state_t      state;
   logic        we;
   logic [31:0] adr;
   logic [31:0] wdat;
   logic [1:0]  cnt;
   logic [1:0]  last;
   logic [15:0] tmo;
   logic [23:0] rbuf;
   logic        cyc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         we       <= 1'b0;
         adr      <= 32'h0;
         wdat     <= 32'h0;
         cnt      <= 2'd0;
         last     <= 2'd0;
         tmo      <= 16'd0;
         rbuf     <= 24'h0;
         cyc      <= 1'b0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= 2'd0;
               if (rx_valid && rx_data == CMD_WRITE) begin
                  we    <= 1'b1;
                  state <= S_ADDR;
               end else if (rx_valid && rx_data == CMD_READ) begin
                  we    <= 1'b0;
                  state <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  adr <= {adr[23:0], rx_data};
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     if (we) begin
                        state <= S_DATA;
                     end else begin
                        state <= S_BUS;
                        cyc   <= 1'b1;
                        tmo   <= 16'd0;
                     end
                  end
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  wdat <= {wdat[23:0], rx_data};
                  cnt  <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     state <= S_BUS;
                     cyc   <= 1'b1;
                     tmo   <= 16'd0;
                  end
               end
            end
            S_BUS: begin
               tmo <= tmo + 16'd1;
               // ack takes priority over a simultaneous err or timeout
               if (m_ack_i) begin
                  cyc      <= 1'b0;
                  tx_valid <= 1'b1;
                  cnt      <= 2'd0;
                  state    <= S_RESP;
                  if (we) begin
                     tx_data <= RSP_OK;
                     last    <= 2'd0;
                  end else begin
                     tx_data <= m_dat_i[31:24];
                     rbuf    <= m_dat_i[23:0];
                     last    <= 2'd3;
                  end
               end else if (m_err_i || tmo == TMO_LAST) begin
                  cyc      <= 1'b0;
                  tx_valid <= 1'b1;
                  tx_data  <= RSP_FAIL;
                  last     <= 2'd0;
                  cnt      <= 2'd0;
                  state    <= S_RESP;
               end
            end
            S_RESP: begin
               if (tx_ready) begin
                  cnt <= cnt + 2'd1;
                  if (cnt == last) begin
                     tx_valid <= 1'b0;
                     cnt      <= 2'd0;
                     state    <= S_IDLE;
                  end else begin
                     tx_data <= rbuf[23:16];
                     rbuf    <= {rbuf[15:0], 8'h00};
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign m_adr_o = adr;
   assign m_dat_o = wdat;
   assign m_sel_o = 4'hF;
   assign m_we_o  = we & cyc;
   assign m_cyc_o = cyc;
   assign m_stb_o = cyc;
   assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_wb_dbg_master.sv
// Self-checking bench for wb_dbg_master: random commands, a scripted Wishbone slave,
// and scoreboards for bus cycles and response bytes.
module tb_wb_dbg_master;

   localparam int TMO = 8;
   localparam int M_ACK = 0, M_ERR = 1, M_ACKERR = 2, M_NONE = 3, M_LATE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] m_adr_o, m_dat_o;
   logic [31:0] m_dat_i = 32'h0;
   logic [3:0]  m_sel_o;
   logic        m_we_o, m_cyc_o, m_stb_o;
   logic        m_ack_i = 1'b0;
   logic        m_err_i = 1'b0;
   logic        busy;

   wb_dbg_master #(.timeout_cycles(TMO)) dut (
      .clk(clk), .reset(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
      .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
      .m_ack_i(m_ack_i), .m_err_i(m_err_i), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      int          len;
   } txn_t;

   txn_t        bus_q[$];
   logic [7:0]  tx_q[$];
   int          checks = 0;
   int          passes = 0;

   // reference state: what the address/data registers should hold between commands
   logic [31:0] cur_adr = 32'h0;
   logic [31:0] cur_dat = 32'h0;

   int          s_mode = M_NONE;
   int          s_lat = 0;
   logic [31:0] s_rdata = 32'h0;
   bit          hold_low = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // scripted slave: fires ack/err on the (lat+1)-th cycle of m_cyc_o
   initial begin : slave
      int c = 0;
      bit prev = 1'b0;
      bit fire;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            m_ack_i = 0; m_err_i = 0; c = 0;
         end else if (m_cyc_o) begin
            c++;
            fire = (c == s_lat + 1);
            m_ack_i = fire && (s_mode == M_ACK || s_mode == M_ACKERR);
            m_err_i = fire && (s_mode == M_ERR || s_mode == M_ACKERR);
            m_dat_i = fire ? s_rdata : $urandom;
         end else begin
            m_ack_i = (s_mode == M_LATE) && prev;
            m_err_i = 0;
            c = 0;
         end
         prev = m_cyc_o;
      end
   end

   initial begin : ready_gen
      forever begin
         @(posedge clk);
         #1;
         tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   // bus monitor: checks each Wishbone cycle against the expected transaction
   initial begin : bus_mon
      bit   incyc = 0;
      int   n = 0;
      txn_t cur;
      forever begin
         @(negedge clk);
         if (rst) begin
            incyc = 0; n = 0;
         end else if (m_cyc_o) begin
            if (!incyc) begin
               if (bus_q.size() == 0) begin
                  chk("unexpected_cycle", {31'h0, m_cyc_o}, 32'h0);
                  cur = '{adr: m_adr_o, dat: m_dat_o, we: m_we_o, len: 0};
               end else begin
                  cur = bus_q.pop_front();
                  chk("bus_adr", m_adr_o, cur.adr);
                  chk("bus_we", {31'h0, m_we_o}, {31'h0, cur.we});
                  if (cur.we) chk("bus_dat", m_dat_o, cur.dat);
                  chk("bus_sel", {28'h0, m_sel_o}, 32'hF);
                  chk("bus_stb", {31'h0, m_stb_o}, 32'h1);
               end
               incyc = 1;
            end
            n++;
         end else if (incyc) begin
            chk("cyc_len", n, cur.len);
            incyc = 0; n = 0;
         end
      end
   end

   // response monitor: pops expected bytes on each accepted transfer
   initial begin : tx_mon
      bit         held = 0;
      logic [7:0] held_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 0;
         end else begin
            if (tx_valid && held) chk("tx_stable", {24'h0, tx_data}, {24'h0, held_data});
            if (tx_valid && tx_ready) begin
               if (tx_q.size() == 0) chk("unexpected_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
               else chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            held = tx_valid && !tx_ready;
            held_data = tx_data;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      send_byte(we ? 8'h57 : 8'h52, 2);
      for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8], 2);
      if (we) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8], 2);
   endtask

   task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input int mode, input int lat, input logic [31:0] rdata);
      bit acked;
      bit done = 0;
      acked = (mode == M_ACK || mode == M_ACKERR);
      s_mode = mode; s_lat = lat; s_rdata = rdata;
      bus_q.push_back('{adr: adr, dat: dat, we: we,
                        len: (mode == M_NONE || mode == M_LATE) ? TMO : lat + 1});
      if (!acked) tx_q.push_back(8'h21);
      else if (we) tx_q.push_back(8'h2E);
      else for (int i = 3; i >= 0; i--) tx_q.push_back(rdata[i*8 +: 8]);
      cur_adr = adr;
      if (we) cur_dat = dat;
      send_frame(we, adr, dat);
      chk("cyc_rise", {31'h0, m_cyc_o}, 32'h1);
      // feed junk (including command bytes) while in BUS/RESP; it must be dropped
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (!busy) begin done = 1; break; end
         if ((m_cyc_o || tx_valid) && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b1;
            rx_data  = ($urandom_range(0, 1) != 0) ? 8'h57 : 8'($urandom);
         end else rx_valid = 1'b0;
      end
      rx_valid = 1'b0;
      chk("cmd_done", {31'h0, done}, 32'h1);
      chk("adr_kept", m_adr_o, cur_adr);
      chk("dat_kept", m_dat_o, cur_dat);
   endtask

   task automatic hit_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_cyc", {31'h0, m_cyc_o}, 32'h0);
      chk("rst_txv", {31'h0, tx_valid}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      tx_q.delete();
      cur_adr = 0; cur_dat = 0;
      s_mode = M_NONE;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold_low = 1'b0;
   endtask

   initial begin : stim
      int w;
      #3 rst = 1'b1;
      #2;
      chk("rst_state", {m_adr_o[15:0], m_dat_o[7:0], tx_data},
          {16'h0, 8'h0, 8'h0});
      chk("rst_ctrl", {tx_valid, m_we_o, m_cyc_o, m_stb_o, busy, m_sel_o}, {5'b0, 4'hF});
      chk("rst_adr", m_adr_o, 32'h0);
      chk("rst_dat", m_dat_o, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_cmd(1, 32'h0000_1000, 32'hDEAD_BEEF, M_ACK, 0, 32'h0);
      run_cmd(0, 32'h7000_0000, 32'h0, M_ACK, 3, 32'h1234_5678);
      run_cmd(0, 32'h5000_0000, 32'h0, M_NONE, 0, 32'h0);
      run_cmd(1, 32'h0000_2000, 32'h0BAD_F00D, M_ERR, 1, 32'h0);
      run_cmd(1, 32'h0000_3000, 32'hCAFE_0001, M_ACKERR, 2, 32'h0);
      run_cmd(0, 32'h0000_4000, 32'h0, M_ACK, TMO - 1, 32'hA5C3_0F96);
      run_cmd(0, 32'h0000_5000, 32'h0, M_LATE, 0, 32'h0);

      // garbage in IDLE: nothing should start
      send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h41, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("garbage_busy", {31'h0, busy}, 32'h0);
      chk("garbage_cyc", {31'h0, m_cyc_o}, 32'h0);

      // reset in the middle of a bus cycle
      s_mode = M_NONE;
      bus_q.push_back('{adr: 32'h1111_2222, dat: 32'h0, we: 0, len: 0});
      send_frame(0, 32'h1111_2222, 32'h0);
      repeat (3) @(posedge clk);
      hit_reset();

      // reset while a response byte is waiting
      hold_low = 1'b1;
      s_mode = M_ACK; s_lat = 0; s_rdata = 32'h7777_8888;
      bus_q.push_back('{adr: 32'h3333_4444, dat: 32'h0, we: 0, len: 1});
      send_frame(0, 32'h3333_4444, 32'h0);
      w = 0;
      while (!tx_valid && w < 50) begin @(posedge clk); #1; w++; end
      chk("resp_reached", {31'h0, tx_valid}, 32'h1);
      repeat (2) @(posedge clk);
      hit_reset();

      run_cmd(1, 32'h0000_1000, 32'hDEAD_BEEF, M_ACK, 0, 32'h0);

      for (int k = 0; k < 30; k++)
         run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 4),
                 $urandom_range(0, TMO - 1), $urandom);

      repeat (4) @(posedge clk);
      chk("tx_q_empty", tx_q.size(), 0);
      chk("bus_q_empty", bus_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
